mux3_arbiter: RTL and testbench
===============================

MUX3_ARBITER -- requirements
Module: mux3_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each requester and of the shared output.
REQ-002 Parameter MAX_BURST, default 8, maximum beats one requester may hold a locked grant (legal range 1-255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  3  per-requester request; bit i = requester i has a beat to send.
REQ-006 lock  input  3  per-requester burst lock; bit i = keep grant after current beat.
REQ-007 data0 / data1 / data2  input  WIDTH each  requester payloads.
REQ-008 out_ready  input  1  sink accepts the beat this cycle.
REQ-009 sel  output  2  shared-mux select: 2'b00/01/10 = requester 0/1/2; 2'b11 = no grant.
REQ-010 data_out  output  WIDTH  selected payload; 0 when sel = 2'b11.
REQ-011 out_valid  output  1  beat on data_out is valid.
REQ-012 ack  output  3  one-hot; bit i high in the cycle requester i's beat transfers.
REQ-013 busy  output  1  high while any grant is held.

Function
REQ-014 States: IDLE (sel = 2'b11) and GRANT (sel = grant index g); state, g, rr_ptr[1:0], beat_cnt[7:0] are registers.
REQ-015 Arbitration: round-robin, search order starts at rr_ptr and wraps 0->1->2->0; the first set req bit wins.
REQ-016 IDLE -> GRANT when any req is set; grant is registered: req seen in cycle N gives sel/out_valid in cycle N+1.
REQ-017 In GRANT: data_out = data[g] combinationally; out_valid = req[g]; transfer = req[g] && out_ready; ack[g] = transfer.
REQ-018 Transfer with lock[g] = 0, or with beat_cnt + 1 = MAX_BURST: rr_ptr <= g+1 (mod 3), beat_cnt <= 0, and a new arbitration is performed in the same cycle over req with the pointer g+1; GRANT to the winner next cycle, IDLE if none.
REQ-019 Transfer with lock[g] = 1 and beat_cnt + 1 < MAX_BURST: g held, beat_cnt increments.
REQ-020 No transfer and req[g] = 1: g, beat_cnt held (sink backpressure, data_out stable).
REQ-021 req[g] drops while granted without transfer: release as in REQ-018 (rr_ptr <= g+1), no ack.
REQ-022 Simultaneous requests: exactly one grant; no requester waits more than 2 x MAX_BURST beats while continuously requesting.
REQ-023 Index 2'b11 is never stored in g; ack is never multi-hot; out_valid is 0 in IDLE.

Reset
REQ-024 rst_n low asynchronously forces IDLE, sel = 2'b11, rr_ptr = 0, beat_cnt = 0, ack = 0, out_valid = 0, busy = 0, data_out = 0.
REQ-025 Reset mid-burst abandons the burst with no ack; first arbitration after release starts from requester 0.

Structure
REQ-026 Shared package holds the state encoding, SEL_NONE = 2'b11, and the SEL0/1/2 codes used by the shared 3-input mux.
REQ-027 The payload path instantiates one 3-input WIDTH-bit mux sub-module (mux3in, driven by sel) plus a zero gate for SEL_NONE; arbitration/counter logic is in mux3_arbiter itself.

Verification
REQ-028 Reset, then req=3'b111, lock=0, out_ready=1 for 6 cycles -> ack sequence 001,010,100,001,010,100 starting cycle after req, sel 00,01,10 repeating.
REQ-029 req=3'b001, lock=3'b001, data0=32'hA5A5_0000+n, out_ready=1, MAX_BURST=8, req[1] also set -> 8 consecutive acks to requester 0, then ack=3'b010.
REQ-030 Requester 2 granted, out_ready=0 for 5 cycles -> sel=2'b10, out_valid=1, data_out=data2 stable, ack=0; out_ready=1 -> single ack=3'b100.
REQ-031 Requester 1 granted, req[1] dropped before out_ready -> no ack, next cycle sel=2'b11 (or 2'b10 if req[2] set), rr_ptr=2.
REQ-032 rst_n pulsed low mid-burst (beat 3 of 8) -> same cycle sel=2'b11, out_valid=0, ack=0; after release req=3'b110 -> requester 1 granted first.
REQ-033 req=0 for 10 cycles -> sel=2'b11, data_out=0, busy=0 throughout.

Source files
------------

// File: rtl/mux3_arbiter_pkg.sv
// Shared encodings and the round-robin pick helper for the 3-way arbiter.
package mux3_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] SEL0     = 2'b00;
  localparam logic [1:0] SEL1     = 2'b01;
  localparam logic [1:0] SEL2     = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } arb_t;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == SEL2) ? SEL0 : idx + 2'd1;
  endfunction

  // Walk the search order backwards so the earliest hit from ptr is the last one written.
  function automatic arb_t arb_pick(input logic [2:0] req, input logic [1:0] ptr);
    arb_t r;
    int   p;
    r.found = 1'b0;
    r.idx   = SEL_NONE;
    for (int k = 2; k >= 0; k--) begin
      p = (int'(ptr) + k) % 3;
      if (req[p]) begin
        r.found = 1'b1;
        r.idx   = 2'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux3_arbiter_mux3in.sv
// Plain 3-input payload mux; the unused select code yields zero.
module mux3in
  import mux3_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL0:    y = d0;
      SEL1:    y = d1;
      SEL2:    y = d2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux3_arbiter.sv
// Three-requester round-robin arbiter with burst lock, driving one shared payload mux.
module mux3_arbiter
  import mux3_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [2:0]       lock,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [2:0]       ack,
  output logic             busy
);

  localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

  logic [0:0] r_state;
  logic [1:0] r_g;
  logic [1:0] r_rr_ptr;
  logic [7:0] r_beat_cnt;

  logic [0:0] w_state_d;
  logic [1:0] w_g_d;
  logic [1:0] w_ptr_d;
  logic [7:0] w_cnt_d;

  logic             w_granted;
  logic             w_transfer;
  logic             w_release;
  arb_t             w_pick_idle;
  arb_t             w_pick_rel;
  logic [WIDTH-1:0] w_mux_y;

  assign w_granted   = (r_state == ST_GRANT);
  assign w_transfer  = w_granted && req[r_g] && out_ready;
  // Release on an unlocked or final-beat transfer, or when the holder withdraws.
  assign w_release   = w_granted &&
                       (!req[r_g] ||
                        (w_transfer && (!lock[r_g] || (r_beat_cnt + 8'd1 == LP_MAX))));
  assign w_pick_idle = arb_pick(req, r_rr_ptr);
  assign w_pick_rel  = arb_pick(req, next_idx(r_g));

  always_comb begin
    w_state_d = r_state;
    w_g_d     = r_g;
    w_ptr_d   = r_rr_ptr;
    w_cnt_d   = r_beat_cnt;
    if (!w_granted) begin
      if (w_pick_idle.found) begin
        w_state_d = ST_GRANT;
        w_g_d     = w_pick_idle.idx;
      end
    end else if (w_release) begin
      w_ptr_d = next_idx(r_g);
      w_cnt_d = 8'd0;
      if (w_pick_rel.found) begin
        w_state_d = ST_GRANT;
        w_g_d     = w_pick_rel.idx;
      end else begin
        w_state_d = ST_IDLE;
      end
    end else if (w_transfer) begin
      w_cnt_d = r_beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_g        <= SEL0;
      r_rr_ptr   <= SEL0;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_d;
      r_g        <= w_g_d;
      r_rr_ptr   <= w_ptr_d;
      r_beat_cnt <= w_cnt_d;
    end
  end

  assign sel       = w_granted ? r_g : SEL_NONE;
  assign out_valid = w_granted && req[r_g];
  assign ack       = w_transfer ? 3'(3'b001 << r_g) : 3'b000;
  assign busy      = w_granted;

  mux3in #(
    .WIDTH (WIDTH)
  ) u_mux3in (
    .sel (sel),
    .d0  (data0),
    .d1  (data1),
    .d2  (data2),
    .y   (w_mux_y)
  );

  assign data_out = (sel == SEL_NONE) ? '0 : w_mux_y;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed bench for mux3_arbiter: inputs change on the falling edge, outputs checked 1ns later.
module tb_mux3_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        out_ready;
  logic [1:0]  sel;
  logic [31:0] data_out;
  logic        out_valid;
  logic [2:0]  ack;
  logic        busy;

  int n_checks;
  int n_pass;

  mux3_arbiter #(
    .WIDTH     (32),
    .MAX_BURST (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .out_ready (out_ready),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = 3'b000;
    lock      = 3'b000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [2:0] ack_seq [6];
    logic [1:0] sel_seq [6];
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b1;
    req       = 3'b000;
    lock      = 3'b000;
    out_ready = 1'b0;
    data0     = 32'h1111_0000;
    data1     = 32'h2222_0001;
    data2     = 32'h3333_0002;
    ack_seq   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    sel_seq   = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

    // Reset state
    do_reset();
    check_eq("rst_sel", 32'(sel), 32'h3);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_data", data_out, 32'h0);

    // All three requesting, no lock: strict rotation
    req       = 3'b111;
    out_ready = 1'b1;
    #1;
    check_eq("rr_first_idle", 32'(sel), 32'h3);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      check_eq($sformatf("rr_ack%0d", k), 32'(ack), 32'(ack_seq[k]));
      check_eq($sformatf("rr_sel%0d", k), 32'(sel), 32'(sel_seq[k]));
    end

    // Locked burst of MAX_BURST beats, then hand-over to requester 1
    do_reset();
    req       = 3'b011;
    lock      = 3'b001;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      data0 = 32'hA5A5_0000 + 32'(n);
      #1;
      check_eq($sformatf("burst_ack%0d", n), 32'(ack), 32'h1);
      check_eq($sformatf("burst_data%0d", n), data_out, 32'hA5A5_0000 + 32'(n));
    end
    next_cycle();
    check_eq("burst_handover", 32'(ack), 32'h2);

    // Backpressure on requester 2
    do_reset();
    req       = 3'b100;
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      next_cycle();
      check_eq($sformatf("bp_sel%0d", n), 32'(sel), 32'h2);
      check_eq($sformatf("bp_valid%0d", n), 32'(out_valid), 32'h1);
      check_eq($sformatf("bp_data%0d", n), data_out, 32'h3333_0002);
      check_eq($sformatf("bp_ack%0d", n), 32'(ack), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ack", 32'(ack), 32'h4);
    @(negedge clk);
    req = 3'b000;
    #1;
    check_eq("bp_single_ack", 32'(ack), 32'h0);

    // Requester 1 withdraws while granted, nothing else pending
    do_reset();
    req = 3'b010;
    next_cycle();
    check_eq("drop_sel", 32'(sel), 32'h1);
    req = 3'b000;
    #1;
    check_eq("drop_ack", 32'(ack), 32'h0);
    check_eq("drop_valid", 32'(out_valid), 32'h0);
    next_cycle();
    check_eq("drop_idle", 32'(sel), 32'h3);
    req = 3'b111;
    next_cycle();
    check_eq("drop_ptr2", 32'(sel), 32'h2);

    // Requester 1 withdraws while requester 2 waits
    do_reset();
    req = 3'b010;
    next_cycle();
    check_eq("drop2_sel", 32'(sel), 32'h1);
    req = 3'b100;
    #1;
    check_eq("drop2_ack", 32'(ack), 32'h0);
    next_cycle();
    check_eq("drop2_next", 32'(sel), 32'h2);

    // Reset in the middle of a locked burst
    do_reset();
    req       = 3'b001;
    lock      = 3'b001;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      check_eq($sformatf("mid_ack%0d", n), 32'(ack), 32'h1);
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_sel", 32'(sel), 32'h3);
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_ack", 32'(ack), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b110;
    lock  = 3'b000;
    #1;
    check_eq("mid_post_idle", 32'(sel), 32'h3);
    next_cycle();
    check_eq("mid_post_grant", 32'(sel), 32'h1);

    // Quiet bus
    do_reset();
    for (int n = 0; n < 10; n++) begin
      next_cycle();
      check_eq($sformatf("quiet_sel%0d", n), 32'(sel), 32'h3);
      check_eq($sformatf("quiet_data%0d", n), data_out, 32'h0);
      check_eq($sformatf("quiet_busy%0d", n), 32'(busy), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
